vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator for the 640x480 @ 60 Hz VGA path; the producer side of the DrawX/DrawY/blank interface that every sprite mapper consumes. Counts pixels and lines on the pixel clock, emits the current draw coordinate, the visible-region flag, and active-low syncs. It also supplies sync copies delayed to match the mappers' ROM-plus-register colour latency, and a frame-locked animation index for multi-frame running sprites.

## Interface
Parameters:
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal pixels; line total 800
- V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical lines; frame total 525
- PIPE_DLY 2: cycles of colour latency in downstream mappers
- ANIM_DIV 8: video frames per animation step (>=1)
- ANIM_FRAMES 3: animation cycle length (>=1, <=4)

Ports:
- vga_clk  in  1  pixel clock (25 MHz); the block's only clock
- reset_n  in  1  asynchronous, active-low reset
- anim_en  in  1  1 = animation divider advances; 0 = divider and index hold
- anim_restart  in  1  synchronous clear of divider and index; overrides anim_en
- DrawX  out  10  current pixel column, 0..799
- DrawY  out  10  current line, 0..524
- blank  out  1  1 = (DrawX,DrawY) in visible region (mapper drives colour when high)
- hs, vs  out  1  active-low syncs aligned with DrawX/DrawY
- hs_dly, vs_dly, blank_dly  out  1  hs/vs/blank delayed PIPE_DLY cycles, for pairing with mapper colour
- frame_start  out  1  one-cycle pulse at (0,0) after a frame wrap
- anim_frame  out  2  sprite animation index, 0..ANIM_FRAMES-1

## Operation
- hc increments every cycle; at 799 wraps to 0 and vc increments; vc wraps 524 -> 0.
- DrawX = hc, DrawY = vc (registered counters, driven directly).
- blank = (hc < 640) && (vc < 480). hs = 0 iff hc in [656,751]; vs = 0 iff vc in [490,491].
- blank/hs/vs registered so they describe the same (DrawX,DrawY) in the same cycle.
- frame_start = 1 for exactly the cycle in which (DrawX,DrawY)=(0,0) following a (799,524) wrap; never in the first cycle after reset.
- Animation: divider counts frame_start pulses while anim_en=1; at count ANIM_DIV-1 plus pulse, divider -> 0 and anim_frame -> (anim_frame+1) mod ANIM_FRAMES. anim_frame changes only in the frame_start cycle, so it is constant across a frame.
- anim_restart=1: divider and anim_frame -> 0 next edge, regardless of anim_en or a simultaneous frame_start.
- anim_en=0 on a frame_start cycle: pulse ignored.

## Timing
- Reset (async assert, any time, mid-line included): DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, anim_frame=0, divider=0, all delay stages hs_dly=1, vs_dly=1, blank_dly=0.
- First edge after release: DrawX=1.
- Delay outputs: x_dly at cycle n equals x at cycle n-PIPE_DLY; for the first PIPE_DLY cycles after reset they show reset values.
- Line period 800 cycles; frame period 420000 cycles; anim step every ANIM_DIV*420000 cycles.
- No combinational path from inputs to outputs.

## Structure
- Package vga_timing_pkg: all H_/V_ timing constants, derived H_TOTAL=800, V_TOTAL=525, sync start/end positions, coordinate width typedef (10 bits).
- Sub-module sync_delay_line: parameterised-depth, parameterised-reset-value 1-bit shift register; three instances for hs/vs/blank.
- Counters, decode, divider in the top level.

## Test plan
- Release reset, run 420000 cycles -> DrawX/DrawY sweep 0..799/0..524 once; frame_start pulses exactly once, at cycle 420000.
- Line check: hs low for 96 cycles starting DrawX=656; blank low from DrawX=640 through 799 and for all DrawY>=480; vs low exactly on lines 490-491.
- Delay check: blank_dly rises exactly 2 cycles after blank at (0,0); hs_dly falls 2 cycles after hs.
- anim_en=1, ANIM_DIV=2, ANIM_FRAMES=3: anim_frame goes 0,1,2,0 at frame_start of frames 2,4,6; holds between.
- anim_en=0 for 3 frames -> anim_frame unchanged; anim_restart coincident with frame_start -> anim_frame=0, divider 0.
- Assert reset_n low at DrawX=300, DrawY=200 -> all outputs at reset values immediately; resumes from (0,0), no frame_start until next full wrap.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 raster timing constants and coordinate type.
// Shared by the sync generator and anything decoding DrawX/DrawY.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_range(
    input coord_t v,
    input coord_t lo,
    input coord_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// 1-bit shift register of configurable depth and reset value,
// used to line sync/blank up with downstream colour latency.
module sync_delay_line #(
  parameter int DEPTH   = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_sr
      logic [DEPTH-1:0] sr;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          sr <= {DEPTH{RST_VAL}};
        end else begin
          sr <= (sr << 1) | DEPTH'(d);
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: counters, registered blank/sync decode,
// delayed sync copies and a frame-locked animation index.
module vga_sync_gen #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int PIPE_DLY    = 2,
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 3
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       anim_en,
  input  logic       anim_restart,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_dly,
  output logic       vs_dly,
  output logic       blank_dly,
  output logic       frame_start,
  output logic [1:0] anim_frame
);

  import vga_timing_pkg::*;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_VIS  = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS  = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
  localparam logic [1:0]       AF_LAST  = 2'(ANIM_FRAMES - 1);

  coord_t           hc;
  coord_t           vc;
  coord_t           hc_nxt;
  coord_t           vc_nxt;
  logic             h_wrap;
  logic             f_wrap;
  logic             blank_nxt;
  logic             hs_nxt;
  logic             vs_nxt;
  logic [DIV_W-1:0] div;

  // Decode from the next count so the flags register alongside it.
  always_comb begin
    h_wrap    = (hc == H_LAST);
    f_wrap    = h_wrap && (vc == V_LAST);
    hc_nxt    = h_wrap ? '0 : hc + 1'b1;
    vc_nxt    = vc;
    if (h_wrap) begin
      vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
    end
    blank_nxt = (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
    hs_nxt    = !in_range(hc_nxt, HS_LO, HS_HI);
    vs_nxt    = !in_range(vc_nxt, VS_LO, VS_HI);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      blank       <= blank_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      frame_start <= f_wrap;
    end
  end

  // Steps on the wrap edge, so the new index appears with frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div        <= '0;
      anim_frame <= '0;
    end else if (anim_restart) begin
      div        <= '0;
      anim_frame <= '0;
    end else if (f_wrap && anim_en) begin
      if (div == DIV_LAST) begin
        div        <= '0;
        anim_frame <= (anim_frame == AF_LAST) ? 2'd0 : anim_frame + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  sync_delay_line #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (1'b1)
  ) u_hs_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       (hs),
    .q       (hs_dly)
  );

  sync_delay_line #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (1'b1)
  ) u_vs_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       (vs),
    .q       (vs_dly)
  );

  sync_delay_line #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (1'b0)
  ) u_blank_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       (blank),
    .q       (blank_dly)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken raster
// (35x19 total) so several frames fit in a short run.
module tb_vga_sync_gen;

  localparam int HA = 20;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 5;
  localparam int VA = 10;
  localparam int VF = 3;
  localparam int VS = 2;
  localparam int VB = 4;
  localparam int HT = 35;
  localparam int VT = 19;
  localparam int FRAME = 665;
  localparam int HS_LO = 24;
  localparam int HS_HI = 29;
  localparam int VS_LO = 13;
  localparam int VS_HI = 14;

  logic       vga_clk;
  logic       reset_n;
  logic       anim_en;
  logic       anim_restart;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       hs_dly;
  logic       vs_dly;
  logic       blank_dly;
  logic       frame_start;
  logic [1:0] anim_frame;

  int checks = 0;
  int errors = 0;

  vga_sync_gen #(
    .H_ACTIVE    (HA),
    .H_FP        (HF),
    .H_SYNC      (HS),
    .H_BP        (HB),
    .V_ACTIVE    (VA),
    .V_FP        (VF),
    .V_SYNC      (VS),
    .V_BP        (VB),
    .PIPE_DLY    (2),
    .ANIM_DIV    (2),
    .ANIM_FRAMES (3)
  ) dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .anim_en      (anim_en),
    .anim_restart (anim_restart),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .hs           (hs),
    .vs           (vs),
    .hs_dly       (hs_dly),
    .vs_dly       (vs_dly),
    .blank_dly    (blank_dly),
    .frame_start  (frame_start),
    .anim_frame   (anim_frame)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic wait_fs(output bit ok, output bit held);
    logic [1:0] a0;
    a0   = anim_frame;
    ok   = 1'b0;
    held = 1'b1;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(posedge vga_clk);
      #1;
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
      if (anim_frame !== a0) held = 1'b0;
    end
  endtask

  task automatic check_pulse(input int p, input logic [1:0] exp_a);
    bit ok;
    bit held;
    wait_fs(ok, held);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fs_timeout pulse %0d: no frame_start", p);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL anim_hold pulse %0d: index moved mid-frame", p);
    end
    checks++;
    if (anim_frame !== exp_a) begin
      errors++;
      $display("FAIL anim pulse %0d: got %0d want %0d",
               p, anim_frame, exp_a);
    end
  endtask

  task automatic test_reset;
    reset_n      = 1'b0;
    anim_en      = 1'b1;
    anim_restart = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    checks++;
    if ({DrawX, DrawY} !== 20'd0) begin
      errors++;
      $display("FAIL rst_xy: got %0d,%0d want 0,0", DrawX, DrawY);
    end
    checks++;
    if ({blank, hs, vs, frame_start} !== 4'b1110) begin
      errors++;
      $display("FAIL rst_flags: got %b want 1110",
               {blank, hs, vs, frame_start});
    end
    checks++;
    if ({hs_dly, vs_dly, blank_dly} !== 3'b110) begin
      errors++;
      $display("FAIL rst_dly: got %b want 110",
               {hs_dly, vs_dly, blank_dly});
    end
    checks++;
    if (anim_frame !== 2'd0) begin
      errors++;
      $display("FAIL rst_anim: got %0d want 0", anim_frame);
    end
  endtask

  task automatic test_sweep;
    int ex, ey;
    logic eb, eh, ev;
    logic b1, b2, h1, h2, v1, v2;
    int hs_low, hs_first, vs_lines, vs_first, vis;
    int bd_rise, hd_fall, h_fall;
    ex = 0; ey = 0;
    eb = 1'b1; eh = 1'b1; ev = 1'b1;
    b1 = 1'b0; b2 = 1'b0;
    h1 = 1'b1; h2 = 1'b1;
    v1 = 1'b1; v2 = 1'b1;
    hs_low = 0; hs_first = -1;
    vs_lines = 0; vs_first = -1;
    vis = 1;
    bd_rise = -1; hd_fall = -1; h_fall = -1;
    @(negedge vga_clk);
    reset_n = 1'b1;
    for (int n = 1; n <= FRAME; n++) begin
      @(posedge vga_clk);
      #1;
      b2 = b1; b1 = eb;
      h2 = h1; h1 = eh;
      v2 = v1; v1 = ev;
      ex++;
      if (ex == HT) begin
        ex = 0;
        ey = (ey == VT - 1) ? 0 : ey + 1;
      end
      eb = (ex < HA) && (ey < VA);
      eh = !((ex >= HS_LO) && (ex <= HS_HI));
      ev = !((ey >= VS_LO) && (ey <= VS_HI));
      checks++;
      if ({DrawX, DrawY} !== {10'(ex), 10'(ey)}) begin
        errors++;
        $display("FAIL xy cyc %0d: got %0d,%0d want %0d,%0d",
                 n, DrawX, DrawY, ex, ey);
      end
      checks++;
      if ({blank, hs, vs} !== {eb, eh, ev}) begin
        errors++;
        $display("FAIL bhv cyc %0d: got %b want %b",
                 n, {blank, hs, vs}, {eb, eh, ev});
      end
      checks++;
      if ({blank_dly, hs_dly, vs_dly} !== {b2, h2, v2}) begin
        errors++;
        $display("FAIL dly cyc %0d: got %b want %b",
                 n, {blank_dly, hs_dly, vs_dly}, {b2, h2, v2});
      end
      checks++;
      if (frame_start !== (n == FRAME)) begin
        errors++;
        $display("FAIL fs cyc %0d: got %b want %b",
                 n, frame_start, n == FRAME);
      end
      if (n < FRAME && blank === 1'b1) vis++;
      if (ey == 0 && hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = ex;
      end
      if (ex == 0 && vs === 1'b0) begin
        vs_lines++;
        if (vs_first < 0) vs_first = ey;
      end
      if (bd_rise < 0 && blank_dly === 1'b1) bd_rise = n;
      if (h_fall < 0 && hs === 1'b0) h_fall = n;
      if (hd_fall < 0 && hs_dly === 1'b0) hd_fall = n;
    end
    checks++;
    if (hs_low != HS || hs_first != HS_LO) begin
      errors++;
      $display("FAIL hs_line: got %0d from %0d want %0d from %0d",
               hs_low, hs_first, HS, HS_LO);
    end
    checks++;
    if (vs_lines != VS || vs_first != VS_LO) begin
      errors++;
      $display("FAIL vs_lines: got %0d from %0d want %0d from %0d",
               vs_lines, vs_first, VS, VS_LO);
    end
    checks++;
    if (vis != HA * VA) begin
      errors++;
      $display("FAIL visible: got %0d want %0d", vis, HA * VA);
    end
    checks++;
    if (bd_rise != 2) begin
      errors++;
      $display("FAIL blank_dly_rise: got %0d want 2", bd_rise);
    end
    checks++;
    if (hd_fall - h_fall != 2) begin
      errors++;
      $display("FAIL hs_dly_fall: got %0d want 2", hd_fall - h_fall);
    end
    checks++;
    if (anim_frame !== 2'd0) begin
      errors++;
      $display("FAIL anim pulse 1: got %0d want 0", anim_frame);
    end
  endtask

  task automatic test_anim_step;
    logic [1:0] exp_a [3] = '{2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) check_pulse(i + 2, exp_a[i]);
  endtask

  task automatic test_anim_hold;
    logic [1:0] exp_a [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    bit         en_v  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      anim_en = en_v[i];
      check_pulse(i + 5, exp_a[i]);
    end
    anim_en = 1'b1;
    check_pulse(10, 2'd0);
    check_pulse(11, 2'd1);
    check_pulse(12, 2'd1);
  endtask

  task automatic test_restart;
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(posedge vga_clk);
      #1;
      if (DrawX == 10'(HT - 1) && DrawY == 10'(VT - 1)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_timeout: last pixel not reached");
    end
    anim_restart = 1'b1;
    @(posedge vga_clk);
    #1;
    checks++;
    if ({frame_start, anim_frame} !== 3'b100) begin
      errors++;
      $display("FAIL restart: got fs %b anim %0d want fs 1 anim 0",
               frame_start, anim_frame);
    end
    @(posedge vga_clk);
    #1;
    anim_restart = 1'b0;
    check_pulse(14, 2'd0);
    check_pulse(15, 2'd1);
  endtask

  task automatic test_mid_reset;
    bit found;
    int fs_n;
    int fs_at;
    found = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(posedge vga_clk);
      #1;
      if (DrawX == 10'd12 && DrawY == 10'd5) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || blank_dly !== 1'b1) begin
      errors++;
      $display("FAIL mid_pos: found %b blank_dly %b want 1 1",
               found, blank_dly);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({DrawX, DrawY} !== 20'd0) begin
      errors++;
      $display("FAIL mid_rst_xy: got %0d,%0d want 0,0", DrawX, DrawY);
    end
    checks++;
    if ({blank, hs, vs, frame_start, anim_frame} !== 6'b111000) begin
      errors++;
      $display("FAIL mid_rst_out: got %b want 111000",
               {blank, hs, vs, frame_start, anim_frame});
    end
    checks++;
    if ({hs_dly, vs_dly, blank_dly} !== 3'b110) begin
      errors++;
      $display("FAIL mid_rst_dly: got %b want 110",
               {hs_dly, vs_dly, blank_dly});
    end
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    fs_n  = 0;
    fs_at = -1;
    for (int n = 1; n <= FRAME; n++) begin
      @(posedge vga_clk);
      #1;
      if (n == 1) begin
        checks++;
        if ({DrawX, DrawY} !== {10'd1, 10'd0}) begin
          errors++;
          $display("FAIL resume_xy: got %0d,%0d want 1,0",
                   DrawX, DrawY);
        end
      end
      if (frame_start === 1'b1) begin
        fs_n++;
        if (fs_at < 0) fs_at = n;
      end
    end
    checks++;
    if (fs_n != 1 || fs_at != FRAME) begin
      errors++;
      $display("FAIL resume_fs: got %0d at %0d want 1 at %0d",
               fs_n, fs_at, FRAME);
    end
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_anim_step;
    test_anim_hold;
    test_restart;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
